// File: rtl/ssd1306_spi_tx.sv
// ---------------------------------------------------------------------------
// ssd1306_spi_tx
//   Write-only 4-wire SPI transmitter (mode 0) for an SSD1306-style panel.
//   Words are queued with their D/C flag in a small FIFO. A five-state FSM
//   serialises each word. Back-to-back words are sent as one chip-select
//   burst. Every FSM state lasts CLK_DIV clk_in cycles.
//
// Ports
//   clk_in, resetn   : clock (rising edge); asynchronous active-low reset
//   in_valid/in_ready: write handshake. in_ready is registered and means
//                      "FIFO not full".
//   in_data, in_dc   : word to send and its D/C flag (1 = data, 0 = command)
//   busy             : FSM not idle, or FIFO holds words
//   fifo_level       : number of occupied FIFO entries
//   spi_ncs/spi_dnc/spi_clk/spi_mosi : panel pins. Each is driven straight
//                      from a flop.
// ---------------------------------------------------------------------------
module ssd1306_spi_tx #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                             clk_in,
  input  logic                             resetn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_dc,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             spi_ncs,
  output logic                             spi_dnc,
  output logic                             spi_clk,
  output logic                             spi_mosi
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUARD,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO
  } state_e;

  // -------------------------------------------------------------------------
  // Word FIFO: {dc, data} per entry. The pointers wrap naturally because
  // the depth is a power of two.
  // -------------------------------------------------------------------------
  logic [DATA_W:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q,  count_d;
  logic            in_ready_q, in_ready_d;
  logic            push, pop, empty;
  logic [DATA_W:0] head;

  assign push  = in_valid && in_ready_q;
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    // pop is only raised when the FIFO is non-empty, and push only when it
    // is not full, so the count stays within 0..FIFO_DEPTH.
    count_d    = count_q + LW'(push) - LW'(pop);
    in_ready_d = (count_d != LW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Storage needs no reset: the pointers and the count define validity.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {in_dc, in_data};
  end

  assign in_ready   = in_ready_q;
  assign fifo_level = count_q;

  // -------------------------------------------------------------------------
  // FSM process 1: state register and datapath registers
  // -------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              dc_q, dc_d;
  logic              div_end;

  assign div_end = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      dc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      dc_q      <= dc_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next state, divider, bit count, shifter, FIFO pop
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    dc_d      = dc_q;
    pop       = 1'b0;

    unique case (state_q)
      // IDLE does not wait out a divider period. It picks up the head word
      // on the first cycle the FIFO is non-empty.
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shreg_d   = head[DATA_W-1:0];
          dc_d      = head[DATA_W];
          bit_cnt_d = '0;
          div_d     = '0;
          state_d   = ST_SETUP;
        end
      end

      ST_GUARD: begin
        if (div_end) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      ST_SETUP: begin
        if (div_end) begin
          div_d   = '0;
          state_d = ST_SHIFT_HI;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      // Leaving the high phase counts one bit. The shifter advances on entry
      // to SHIFT_LO, except after the last bit, so MOSI holds the final bit.
      ST_SHIFT_HI: begin
        if (div_end) begin
          div_d     = '0;
          bit_cnt_d = bit_cnt_q + BW'(1);
          state_d   = ST_SHIFT_LO;
          if (bit_cnt_q != BW'(DATA_W - 1)) begin
            shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      ST_SHIFT_LO: begin
        if (div_end) begin
          div_d = '0;
          if (bit_cnt_q == BW'(DATA_W)) begin
            if (!empty) begin
              // Burst: chip select stays low straight into the next SETUP.
              pop       = 1'b1;
              shreg_d   = head[DATA_W-1:0];
              dc_d      = head[DATA_W];
              bit_cnt_d = '0;
              state_d   = ST_SETUP;
            end else begin
              state_d = ST_GUARD;
            end
          end else begin
            state_d = ST_SHIFT_HI;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: pin values. They are computed from the next state and
  // registered, so the pins line up with state_q without any combinational
  // path to the outputs.
  // -------------------------------------------------------------------------
  logic ncs_q, ncs_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic dnc_q, dnc_d;

  always_comb begin
    ncs_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT_HI) ||
               (state_d == ST_SHIFT_LO));
    sclk_d = (state_d == ST_SHIFT_HI);
    mosi_d = (MSB_FIRST != 0) ? shreg_d[DATA_W-1] : shreg_d[0];
    // dc only changes when a word is loaded, so D/C can only move at a SETUP
    // entry, which is always while SCLK is low.
    dnc_d  = dc_d;
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      ncs_q  <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      dnc_q  <= 1'b0;
    end else begin
      ncs_q  <= ncs_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      dnc_q  <= dnc_d;
    end
  end

  assign spi_ncs  = ncs_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_dnc  = dnc_q;
  assign busy     = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
module tb_ssd1306_spi_tx;
  logic clk_in = 1'b0;
  logic resetn = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_fail = 0;

  // DUT A: defaults (8 bits, CLK_DIV 2, depth 4, MSB first)
  logic       a_valid = 1'b0, a_dc = 1'b0;
  logic [7:0] a_data = '0;
  logic       a_ready, a_busy, a_ncs, a_dnc, a_clk, a_mosi;
  logic [2:0] a_level;

  ssd1306_spi_tx #(.DATA_W(8), .CLK_DIV(2), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_a (
    .clk_in(clk_in), .resetn(resetn), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_dc(a_dc), .busy(a_busy), .fifo_level(a_level),
    .spi_ncs(a_ncs), .spi_dnc(a_dnc), .spi_clk(a_clk), .spi_mosi(a_mosi));

  // DUT B: 9 bits, CLK_DIV 1, LSB first
  logic       b_valid = 1'b0, b_dc = 1'b0;
  logic [8:0] b_data = '0;
  logic       b_ready, b_busy, b_ncs, b_dnc, b_clk, b_mosi;
  logic [2:0] b_level;

  ssd1306_spi_tx #(.DATA_W(9), .CLK_DIV(1), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_b (
    .clk_in(clk_in), .resetn(resetn), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_dc(b_dc), .busy(b_busy), .fifo_level(b_level),
    .spi_ncs(b_ncs), .spi_dnc(b_dnc), .spi_clk(b_clk), .spi_mosi(b_mosi));

  // Panel-side monitor for A: bits are sampled at SCLK rising edges and
  // assembled in arrival order (first bit ends up in the MSB).
  int         ma_bits = 0, ma_low = 0, ma_dchg = 0, ma_dpos = -1, ma_viol = 0;
  logic       ma_dsclk = 1'b0;
  logic [7:0] ma_rx = '0;
  logic       pa_sclk = 1'b0, pa_ncs = 1'b1, pa_dnc = 1'b0;
  logic [7:0] qa_word[$];
  logic       qa_dc[$];
  int         qa_len[$];

  always @(negedge clk_in) begin
    if (!resetn) begin
      ma_bits <= 0; ma_low <= 0; ma_rx <= '0;
      pa_sclk <= 1'b0; pa_ncs <= 1'b1; pa_dnc <= 1'b0;
    end else begin
      pa_sclk <= a_clk; pa_ncs <= a_ncs; pa_dnc <= a_dnc;
      if (a_clk && (a_dnc != pa_dnc)) ma_viol <= ma_viol + 1;
      if (!a_ncs) begin
        if (pa_ncs) begin
          ma_low <= 1; ma_dchg <= 0; ma_dpos <= -1; ma_dsclk <= 1'b0;
        end else begin
          ma_low <= ma_low + 1;
          if (a_dnc != pa_dnc) begin
            ma_dchg <= ma_dchg + 1;
            if (ma_dchg == 0) begin ma_dpos <= ma_low; ma_dsclk <= a_clk; end
          end
        end
        if (a_clk && !pa_sclk) begin
          if (ma_bits == 7) begin
            qa_word.push_back({ma_rx[6:0], a_mosi});
            qa_dc.push_back(a_dnc);
            ma_bits <= 0; ma_rx <= '0;
          end else begin
            ma_bits <= ma_bits + 1; ma_rx <= {ma_rx[6:0], a_mosi};
          end
        end
      end else if (!pa_ncs) begin
        qa_len.push_back(ma_low);
      end
    end
  end

  // Monitor for B (frame length and 9-bit words in arrival order)
  int         mb_bits = 0, mb_low = 0;
  logic [8:0] mb_rx = '0;
  logic       pb_sclk = 1'b0, pb_ncs = 1'b1;
  logic [8:0] qb_word[$];
  int         qb_len[$];

  always @(negedge clk_in) begin
    if (!resetn) begin
      mb_bits <= 0; mb_low <= 0; mb_rx <= '0; pb_sclk <= 1'b0; pb_ncs <= 1'b1;
    end else begin
      pb_sclk <= b_clk; pb_ncs <= b_ncs;
      if (!b_ncs) begin
        mb_low <= pb_ncs ? 1 : mb_low + 1;
        if (b_clk && !pb_sclk) begin
          if (mb_bits == 8) begin
            qb_word.push_back({mb_rx[7:0], b_mosi});
            mb_bits <= 0; mb_rx <= '0;
          end else begin
            mb_bits <= mb_bits + 1; mb_rx <= {mb_rx[7:0], b_mosi};
          end
        end
      end else if (!pb_ncs) begin
        qb_len.push_back(mb_low);
      end
    end
  end

  task automatic push_a(input logic [7:0] d, input logic dc);
    bit ok = 1'b0;
    @(negedge clk_in);
    a_valid = 1'b1; a_data = d; a_dc = dc;
    for (int i = 0; i < 500; i++) begin
      if (a_ready) begin ok = 1'b1; break; end
      @(negedge clk_in);
    end
    @(posedge clk_in); #1;
    a_valid = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL push_a timeout: in_ready=%b required 1", a_ready);
    end
  endtask

  task automatic push_b(input logic [8:0] d);
    @(negedge clk_in);
    b_valid = 1'b1; b_data = d; b_dc = 1'b1;
    n_chk++;
    if (b_ready !== 1'b1) begin
      n_fail++; $display("FAIL push_b ready: got %b required 1", b_ready);
    end
    @(posedge clk_in); #1;
    b_valid = 1'b0;
  endtask

  task automatic wait_len_a(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in); #1;
      if (qa_len.size() >= n) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_len_a timeout: frames=%0d required %0d", qa_len.size(), n);
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in); #1;
      if (!a_busy) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_idle_a timeout: busy=%b required 0", a_busy);
  endtask

  task automatic clear_a();
    qa_word.delete(); qa_dc.delete(); qa_len.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    n_chk += 7;
    if (a_ncs !== 1'b1)    begin n_fail++; $display("FAIL %s ncs: got %b required 1", tag, a_ncs); end
    if (a_clk !== 1'b0)    begin n_fail++; $display("FAIL %s sclk: got %b required 0", tag, a_clk); end
    if (a_mosi !== 1'b0)   begin n_fail++; $display("FAIL %s mosi: got %b required 0", tag, a_mosi); end
    if (a_dnc !== 1'b0)    begin n_fail++; $display("FAIL %s dnc: got %b required 0", tag, a_dnc); end
    if (a_ready !== 1'b1)  begin n_fail++; $display("FAIL %s in_ready: got %b required 1", tag, a_ready); end
    if (a_busy !== 1'b0)   begin n_fail++; $display("FAIL %s busy: got %b required 0", tag, a_busy); end
    if (a_level !== 3'd0)  begin n_fail++; $display("FAIL %s level: got %0d required 0", tag, a_level); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    #1;
    check_reset_vals("reset");
    resetn = 1'b1;
  endtask

  task automatic test_single_word();
    clear_a();
    push_a(8'h69, 1'b0);
    n_chk += 2;
    if (a_level !== 3'd1) begin n_fail++; $display("FAIL single level: got %0d required 1", a_level); end
    if (a_busy !== 1'b1)  begin n_fail++; $display("FAIL single busy: got %b required 1", a_busy); end
    wait_len_a(1, 200);
    n_chk += 6;
    if (qa_len.size() != 1 || qa_len[0] != 34) begin
      n_fail++; $display("FAIL single frame_len: got %0d required 34", (qa_len.size() > 0) ? qa_len[0] : -1);
    end
    if (qa_word.size() != 1 || qa_word[0] !== 8'h69) begin
      n_fail++; $display("FAIL single word: got %0d words, first %h required 1 word 69", qa_word.size(), (qa_word.size() > 0) ? qa_word[0] : 8'hxx);
    end
    if (qa_dc.size() != 1 || qa_dc[0] !== 1'b0) begin
      n_fail++; $display("FAIL single dnc: got count %0d required one word with dc 0", qa_dc.size());
    end
    if (ma_viol != 0) begin n_fail++; $display("FAIL single dnc_while_sclk: got %0d required 0", ma_viol); end
    if (a_ncs !== 1'b1) begin n_fail++; $display("FAIL single ncs_hi_1: got %b required 1", a_ncs); end
    @(negedge clk_in); #1;
    if (a_ncs !== 1'b1) begin n_fail++; $display("FAIL single ncs_hi_2: got %b required 1", a_ncs); end
  endtask

  task automatic test_back_to_back();
    wait_idle_a();
    clear_a();
    push_a(8'hAE, 1'b0);
    push_a(8'hFF, 1'b1);
    push_a(8'h00, 1'b1);
    wait_len_a(1, 400);
    n_chk += 7;
    if (qa_len.size() != 1 || qa_len[0] != 102) begin
      n_fail++; $display("FAIL burst frame_len: got %0d required 102", (qa_len.size() > 0) ? qa_len[0] : -1);
    end
    if (qa_word.size() != 3) begin
      n_fail++; $display("FAIL burst word_count: got %0d required 3", qa_word.size());
    end else begin
      if (qa_word[0] !== 8'hAE || qa_word[1] !== 8'hFF || qa_word[2] !== 8'h00) begin
        n_fail++; $display("FAIL burst words: got %h %h %h required ae ff 00", qa_word[0], qa_word[1], qa_word[2]);
      end
      if (qa_dc[0] !== 1'b0 || qa_dc[1] !== 1'b1 || qa_dc[2] !== 1'b1) begin
        n_fail++; $display("FAIL burst dcs: got %b%b%b required 011", qa_dc[0], qa_dc[1], qa_dc[2]);
      end
    end
    if (ma_dchg != 1) begin n_fail++; $display("FAIL burst dnc_changes: got %0d required 1", ma_dchg); end
    if (ma_dpos != 34) begin n_fail++; $display("FAIL burst dnc_pos: got %0d required 34", ma_dpos); end
    if (ma_dsclk !== 1'b0) begin n_fail++; $display("FAIL burst dnc_sclk: got %b required 0", ma_dsclk); end
    if (ma_viol != 0) begin n_fail++; $display("FAIL burst dnc_while_sclk: got %0d required 0", ma_viol); end
  endtask

  task automatic test_full_fifo();
    logic [7:0] exp_w[16];
    int  idx = 0, max_lvl = 0, bad = 0;
    bit  saw_full = 1'b0, acc;
    for (int i = 0; i < 16; i++) exp_w[i] = 8'h30 + 8'(i * 7);
    wait_idle_a();
    clear_a();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_in); #1;
      if (int'(a_level) > max_lvl) max_lvl = int'(a_level);
      if (a_valid && !a_ready && a_level == 3'd4) saw_full = 1'b1;
      if (idx == 16) break;
      a_valid = 1'b1; a_data = exp_w[idx]; a_dc = idx[0];
      acc = a_ready;
      @(posedge clk_in);
      if (acc) idx++;
    end
    a_valid = 1'b0;
    n_chk += 3;
    if (idx != 16) begin n_fail++; $display("FAIL full pushed: got %0d required 16", idx); end
    if (max_lvl != 4) begin n_fail++; $display("FAIL full max_level: got %0d required 4", max_lvl); end
    if (!saw_full) begin n_fail++; $display("FAIL full refused: got 0 required 1"); end
    for (int c = 0; c < 1500 && qa_word.size() < 16; c++) @(negedge clk_in);
    #1;
    n_chk++;
    if (qa_word.size() != 16) begin
      n_fail++; $display("FAIL full word_count: got %0d required 16", qa_word.size());
    end else begin
      for (int i = 0; i < 16; i++)
        if (qa_word[i] !== exp_w[i] || qa_dc[i] !== 1'(i & 1)) bad++;
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL full words: got %0d bad words required 0", bad); end
    end
  endtask

  task automatic test_reset_midword();
    int idle_bad = 0;
    bit hit = 1'b0;
    wait_idle_a();
    clear_a();
    push_a(8'hC3, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in); #1;
      if (ma_bits == 4 && a_clk) begin hit = 1'b1; break; end
    end
    n_chk++;
    if (!hit) begin n_fail++; $display("FAIL rst 4th_sclk: got 0 required 1"); end
    resetn = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (3) @(negedge clk_in);
    #1 resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in); #1;
      if (a_ncs !== 1'b1 || a_clk !== 1'b0) idle_bad++;
    end
    n_chk += 2;
    if (idle_bad != 0) begin n_fail++; $display("FAIL rst idle_after: got %0d active cycles required 0", idle_bad); end
    if (qa_word.size() != 0 || qa_len.size() != 0) begin
      n_fail++; $display("FAIL rst aborted: got %0d words %0d frames required 0 0", qa_word.size(), qa_len.size());
    end
    push_a(8'h5A, 1'b0);
    wait_len_a(1, 200);
    n_chk += 2;
    if (qa_len.size() != 1 || qa_len[0] != 34) begin
      n_fail++; $display("FAIL rst frame_len: got %0d required 34", (qa_len.size() > 0) ? qa_len[0] : -1);
    end
    if (qa_word.size() != 1 || qa_word[0] !== 8'h5A || qa_dc[0] !== 1'b0) begin
      n_fail++; $display("FAIL rst word: got %0d words first %h required 5a", qa_word.size(), (qa_word.size() > 0) ? qa_word[0] : 8'hxx);
    end
  endtask

  task automatic test_param_sweep();
    bit done = 1'b0;
    qb_word.delete(); qb_len.delete();
    push_b(9'h1A5);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in); #1;
      if (qb_len.size() >= 1) begin done = 1'b1; break; end
    end
    n_chk += 3;
    if (!done) begin n_fail++; $display("FAIL sweep timeout: frames=0 required 1"); end
    if (qb_len.size() != 1 || qb_len[0] != 19) begin
      n_fail++; $display("FAIL sweep frame_len: got %0d required 19", (qb_len.size() > 0) ? qb_len[0] : -1);
    end
    // 0x1A5 LSB first: 1,0,1,0,0,1,0,1,1 -> arrival-ordered 1_0100_1011
    if (qb_word.size() != 1 || qb_word[0] !== 9'b1_0100_1011) begin
      n_fail++; $display("FAIL sweep bits: got %b required 101001011", (qb_word.size() > 0) ? qb_word[0] : 9'bx);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_full_fifo();
    test_reset_midword();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
